sar_controller_mc: RTL and testbench
====================================

Name: sar_controller_mc

Overview:
Parametrised multi-channel successive-approximation controller. It drives the shared sample/hold and DAC of a SAR ADC front end. It scans CHANNELS analogue inputs round-robin, performs one WIDTH-bit binary search per channel, and reports each result tagged with its channel number. It supports single-shot and continuous modes, a programmable sample window and clean abort.

Parameters:
WIDTH, 8, conversion resolution in bits (>=2)
CHANNELS, 4, number of multiplexed inputs (>=1)
SAMPLE_CYCLES, 1, clock cycles sample is held high per conversion (>=1)
CH_W, max(1,$clog2(CHANNELS)), derived channel index width (localparam)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
go  input  1  level enable; low aborts and idles the controller
cont  input  1  1 = continuous scan, 0 = one conversion per go assertion
cmp  input  1  comparator output; 1 = Vin >= DAC, sampled every CONV cycle
sample  output  1  sample/hold control, high during SAMPLE state
ch_sel  output  CH_W  analogue mux select of channel currently being converted
dac_value  output  WIDTH  DAC code = trial | mask (combinational from registers)
busy  output  1  high in SAMPLE, CONV and DONE
result  output  WIDTH  last completed conversion code, held until next DONE
result_ch  output  CH_W  channel of result
valid  output  1  one-cycle pulse, result/result_ch newly updated

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0, including sample, valid, busy, result, result_ch, ch_sel and dac_value. Internal trial, mask and the sample counter are 0.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE: go=1 -> SAMPLE. ch_sel keeps its current value. In single-shot mode a new conversion also requires go to have been low since the last DONE (edge arm flag, set on reset).
- SAMPLE: sample=1. The counter runs for SAMPLE_CYCLES cycles. On the last cycle: mask <= 1<<(WIDTH-1), trial <= 0, state -> CONV.
- CONV: sample=0. Each cycle, dac_value = trial|mask. If cmp=1 then trial <= trial|mask. Then mask <= mask>>1. The cycle in which mask[0]=1 is the last; state -> DONE. CONV therefore lasts exactly WIDTH cycles.
- DONE (1 cycle): result <= trial, result_ch <= ch_sel, and valid=1 for this cycle only. ch_sel <= (ch_sel==CHANNELS-1) ? 0 : ch_sel+1. Next state is SAMPLE if cont=1 and go=1, otherwise IDLE.
- Latency: go sampled high at edge E0 in IDLE gives valid=1 after edge E0+SAMPLE_CYCLES+WIDTH. In continuous mode the conversion period is SAMPLE_CYCLES+WIDTH+1 cycles.
- Abort: go=0 at any edge in SAMPLE or CONV -> IDLE on that edge. On abort, mask is cleared, no valid is issued, ch_sel is not advanced (the channel is retried), and result/result_ch are unchanged. go=0 in DONE still completes DONE (result published) and then goes to IDLE.
- cont is sampled only in DONE; changing it mid-conversion has no effect on the current conversion.
- dac_value equals trial outside CONV, because mask=0 there.
- CHANNELS=1: ch_sel is constantly 0 and the wrap logic is a no-op.
- Simultaneous rst and any input: rst wins.

Test Plan:
1. Reset: assert rst mid-run -> all outputs 0 immediately (before the next clk edge); after release with go=0, stays IDLE, sample=0, busy=0.
2. Single shot, WIDTH=8, SAMPLE_CYCLES=1, comparator model Vin=0xA5, cont=0: raise go -> sample high 1 cycle; dac_value sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; valid pulses exactly once 9 edges after go sampled; result=0xA5, result_ch=0; holding go high gives no second conversion.
3. Continuous scan, CHANNELS=4, Vin per channel {0x00,0xFF,0x3C,0x81}: result_ch sequence 0,1,2,3,0; results match per channel; valid period = 10 cycles.
4. Abort: go low on the 4th CONV cycle of channel 2 -> IDLE next edge, no valid, result holds prior value; next go reconverts channel 2.
5. Parameter sweep: WIDTH=12, SAMPLE_CYCLES=3, CHANNELS=1, Vin=0xFFF then 0x000 -> sample high 3 cycles; results 0xFFF then 0x000; ch_sel stays 0; valid 15 edges after go.
6. Async reset during DONE -> valid drops immediately, result cleared to 0, ch_sel=0.

Source files
------------

// File: rtl/sar_controller_mc_if.sv
// SAR controller bus: comparator/enable inputs and S/H, DAC, result outputs.
// No latency of its own; pure signal bundle.
// No backpressure: valid is a one-cycle pulse with no ready.
//
// Ports (signals):
//   go, cont, cmp              host/front end -> controller
//   sample, ch_sel, dac_value  controller -> analogue front end
//   busy, result, result_ch,
//   valid                      controller -> host
// Modports: master = host/front-end side, slave = controller.
interface sar_controller_mc_if #(
    parameter int WIDTH = 8,
    parameter int CH_W  = 2
);
    logic             go;
    logic             cont;
    logic             cmp;
    logic             sample;
    logic [CH_W-1:0]  ch_sel;
    logic [WIDTH-1:0] dac_value;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic [CH_W-1:0]  result_ch;
    logic             valid;

    modport master (
        output go, cont, cmp,
        input  sample, ch_sel, dac_value, busy, result, result_ch, valid
    );

    modport slave (
        input  go, cont, cmp,
        output sample, ch_sel, dac_value, busy, result, result_ch, valid
    );
endinterface

// File: rtl/sar_controller_mc.sv
// Multi-channel SAR controller: round-robin binary search, one result per channel.
// Latency: go seen at edge E0 -> valid after edge E0+SAMPLE_CYCLES+WIDTH.
// No backpressure: results are pulsed with valid; go=0 aborts SAMPLE/CONV.
//
// Ports:
//   clk, rst   clock (rising edge) and async active-high reset
//   bus.slave  go/cont/cmp in; sample, ch_sel, dac_value, busy,
//              result, result_ch, valid out
module sar_controller_mc #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int SAMPLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sar_controller_mc_if.slave   bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] mask;
    logic [CNT_W-1:0] cnt;
    logic             armed;   // go has been low since the last DONE
    logic             sample_q;
    logic             busy_q;
    logic             valid_q;
    logic [CH_W-1:0]  ch_sel_q;
    logic [WIDTH-1:0] result_q;
    logic [CH_W-1:0]  result_ch_q;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == LAST_CH) ? '0 : ch + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            trial       <= '0;
            mask        <= '0;
            cnt         <= '0;
            armed       <= 1'b1;
            sample_q    <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            ch_sel_q    <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.go) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // single-shot needs a fresh go; continuous restarts on level
                    if (bus.go && (bus.cont || armed)) begin
                        state    <= SAMPLE;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                SAMPLE: begin
                    if (!bus.go) begin
                        state    <= IDLE;
                        sample_q <= 1'b0;
                        busy_q   <= 1'b0;
                        mask     <= '0;
                        cnt      <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state    <= CONV;
                        sample_q <= 1'b0;
                        mask     <= MSB;
                        trial    <= '0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (!bus.go) begin
                        // abort: channel not advanced, result untouched
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        mask   <= '0;
                    end else begin
                        if (bus.cmp) begin
                            trial <= trial | mask;
                        end
                        mask <= mask >> 1;
                        if (mask[0]) begin
                            // Publish on the edge into DONE so result/result_ch
                            // are already updated while valid is high.
                            state       <= DONE;
                            result_q    <= bus.cmp ? (trial | mask) : trial;
                            result_ch_q <= ch_sel_q;
                            ch_sel_q    <= next_ch(ch_sel_q);
                            valid_q     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    armed <= ~bus.go;
                    if (bus.cont && bus.go) begin
                        state    <= SAMPLE;
                        sample_q <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // mask is zero outside CONV, so this equals trial there
    assign bus.dac_value = trial | mask;
    assign bus.sample    = sample_q;
    assign bus.busy      = busy_q;
    assign bus.valid     = valid_q;
    assign bus.ch_sel    = ch_sel_q;
    assign bus.result    = result_q;
    assign bus.result_ch = result_ch_q;
endmodule

// File: tb/tb_sar_controller_mc.sv
// Bench for sar_controller_mc: two instances (8b/4ch/1-cycle sample and
// 12b/1ch/3-cycle sample) driven by an ideal comparator model.
// Results are scored against the sampled input voltage and channel order.
module tb_sar_controller_mc;
    localparam int WA = 8,  CA = 4, SA = 1;
    localparam int WB = 12, CB = 1, SB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_controller_mc_if #(.WIDTH(WA), .CH_W(2)) a ();
    sar_controller_mc_if #(.WIDTH(WB), .CH_W(1)) b ();

    sar_controller_mc #(.WIDTH(WA), .CHANNELS(CA), .SAMPLE_CYCLES(SA)) u_a (
        .clk(clk), .rst(rst), .bus(a.slave));
    sar_controller_mc #(.WIDTH(WB), .CHANNELS(CB), .SAMPLE_CYCLES(SB)) u_b (
        .clk(clk), .rst(rst), .bus(b.slave));

    // ideal comparator per channel
    logic [WA-1:0] vin_a [CA];
    logic [WB-1:0] vin_b;
    assign a.cmp = (vin_a[a.ch_sel] >= a.dac_value);
    assign b.cmp = (vin_b >= b.dac_value);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // expected DAC code in step j of a binary search for v
    function automatic int traj(input int v, input int j, input int w);
        int lo;
        lo = w - j;
        return ((v >> lo) << lo) | (1 << (w - 1 - j));
    endfunction

    // scoreboard: results must equal the input, channels advance round-robin
    int exp_ch_a = 0;
    int vcnt_a = 0;
    int vcnt_b = 0;
    logic prev_va = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_ch_a = 0;
            prev_va  = 1'b0;
        end else begin
            if (a.valid) begin
                check("sb_result_a", 32'(a.result), 32'(vin_a[exp_ch_a]));
                check("sb_result_ch_a", 32'(a.result_ch), 32'(exp_ch_a));
                check("valid_one_cycle_a", 32'(prev_va), 32'd0);
                vcnt_a++;
                exp_ch_a = (exp_ch_a + 1) % CA;
            end
            prev_va = a.valid;
            if (b.valid) begin
                check("sb_result_b", 32'(b.result), 32'(vin_b));
                check("sb_result_ch_b", 32'(b.result_ch), 32'd0);
                vcnt_b++;
            end
        end
    end

    task automatic wait_valid_a(output int t);
        int n;
        n = 0;
        t = -1;
        while (n < 100) begin
            @(negedge clk);
            if (a.valid) begin
                t = cyc;
                break;
            end
            n++;
        end
        check("valid_timeout_a", 32'(t >= 0), 32'd1);
    endtask

    task automatic single_a();
        int ch0, v0;
        ch0 = exp_ch_a;
        v0  = vcnt_a;
        @(negedge clk);
        a.go = 1'b1;
        for (int k = 0; k <= SA + WA; k++) begin
            @(posedge clk); #1;
            check("sample_a", 32'(a.sample), 32'(k < SA));
            check("valid_time_a", 32'(a.valid), 32'(k == SA + WA));
            if (k >= SA && k < SA + WA)
                check("dac_a", 32'(a.dac_value), 32'(traj(int'(vin_a[ch0]), k - SA, WA)));
        end
        check("result_a", 32'(a.result), 32'(vin_a[ch0]));
        check("result_ch_a", 32'(a.result_ch), 32'(ch0));
        repeat (25) @(negedge clk);
        check("one_shot_count_a", 32'(vcnt_a - v0), 32'd1);
        a.go = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic single_b();
        int v0;
        v0 = vcnt_b;
        @(negedge clk);
        b.go = 1'b1;
        for (int k = 0; k <= SB + WB; k++) begin
            @(posedge clk); #1;
            check("sample_b", 32'(b.sample), 32'(k < SB));
            check("valid_time_b", 32'(b.valid), 32'(k == SB + WB));
            check("ch_sel_b", 32'(b.ch_sel), 32'd0);
            if (k >= SB && k < SB + WB)
                check("dac_b", 32'(b.dac_value), 32'(traj(int'(vin_b), k - SB, WB)));
        end
        check("result_b", 32'(b.result), 32'(vin_b));
        repeat (5) @(negedge clk);
        check("one_shot_count_b", 32'(vcnt_b - v0), 32'd1);
        b.go = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t [5];
        int guard, v0;
        logic [WA-1:0] prev_res;

        a.go = 1'b0; a.cont = 1'b0;
        b.go = 1'b0; b.cont = 1'b0;
        for (int i = 0; i < CA; i++) vin_a[i] = WA'($urandom);
        vin_a[0] = 8'hA5;
        vin_b = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_sample", 32'(a.sample), 32'd0);
        check("rst_busy", 32'(a.busy), 32'd0);
        check("rst_valid", 32'(a.valid), 32'd0);
        check("rst_result", 32'(a.result), 32'd0);
        check("rst_ch_sel", 32'(a.ch_sel), 32'd0);
        check("rst_dac", 32'(a.dac_value), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(a.busy), 32'd0);
        check("idle_sample", 32'(a.sample), 32'd0);

        // single shots, channels 0..3 (first is 0xA5 on channel 0)
        for (int i = 0; i < CA; i++) single_a();

        // continuous scan
        vin_a[0] = 8'h00; vin_a[1] = 8'hFF; vin_a[2] = 8'h3C; vin_a[3] = 8'h81;
        @(negedge clk);
        a.cont = 1'b1;
        a.go   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid_a(t[i]);
            check("cont_ch", 32'(a.result_ch), 32'(i % CA));
            if (i > 0) check("cont_period", 32'(t[i] - t[i-1]), 32'(SA + WA + 1));
        end
        a.cont = 1'b0;
        repeat (2) @(negedge clk);
        a.go = 1'b0;
        repeat (2) @(negedge clk);
        check("cont_stop_busy", 32'(a.busy), 32'd0);

        // abort on 4th CONV cycle of channel 2
        guard = 0;
        while (exp_ch_a != 2 && guard < CA) begin
            single_a();
            guard++;
        end
        prev_res = a.result;
        v0 = vcnt_a;
        @(negedge clk);
        a.go = 1'b1;
        for (int k = 0; k <= SA + 3; k++) begin
            @(posedge clk); #1;
        end
        check("abort_pre_dac", 32'(a.dac_value), 32'(traj(int'(vin_a[2]), 3, WA)));
        @(negedge clk);
        a.go = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(a.busy), 32'd0);
        check("abort_sample", 32'(a.sample), 32'd0);
        repeat (15) @(negedge clk);
        check("abort_no_valid", 32'(vcnt_a - v0), 32'd0);
        check("abort_result_hold", 32'(a.result), 32'(prev_res));
        check("abort_ch_hold", 32'(a.ch_sel), 32'd2);
        single_a();
        check("retry_ch", 32'(a.result_ch), 32'd2);

        // wide, slow-sample, single-channel instance
        vin_b = 12'hFFF;
        single_b();
        vin_b = 12'h000;
        single_b();

        // randomized runs: random inputs, mode and abort point
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < CA; i++) vin_a[i] = WA'($urandom);
            @(negedge clk);
            a.cont = 1'($urandom_range(0, 1));
            a.go   = 1'b1;
            repeat ($urandom_range(1, 40)) @(negedge clk);
            a.go = 1'b0;
            repeat (3) @(negedge clk);
            check("rand_idle", 32'(a.busy), 32'd0);
        end

        // async reset during DONE
        @(negedge clk);
        a.cont = 1'b1;
        a.go   = 1'b1;
        wait_valid_a(t[0]);
        #2;
        rst = 1'b1;
        #1;
        check("rst_done_valid", 32'(a.valid), 32'd0);
        check("rst_done_result", 32'(a.result), 32'd0);
        check("rst_done_ch_sel", 32'(a.ch_sel), 32'd0);
        check("rst_done_busy", 32'(a.busy), 32'd0);
        a.go = 1'b0;
        a.cont = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
